// File: rtl/mlp_seq_ctrl.sv
// mlp_seq_ctrl: parametrised layer sequencer walking fully-connected layers over images,
// streaming source/weight reads, driving the MAC handshake and draining results.
module mlp_seq_ctrl #(
    parameter int NUM_LAYERS = 5,
    parameter int IMG_NUM = 1,
    parameter int MAX_IN = 784,
    parameter int MAX_OUT = 64,
    parameter logic [16*NUM_LAYERS-1:0] LAYER_IN = {16'd16, 16'd32, 16'd32, 16'd64, 16'd784},
    parameter logic [16*NUM_LAYERS-1:0] LAYER_OUT = {16'd10, 16'd16, 16'd32, 16'd32, 16'd64},
    parameter int FP_BW = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAC_LATENCY = 4,
    parameter int RELU_EN = 1,
    parameter int Y_ADDR_STEP = 4,
    parameter int Y_ADDR_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic done_intr_o,
    output logic done_led_o,
    output logic src_buf_en_o,
    output logic [1:0] src_sel_o,
    output logic [$clog2(MAX_IN*IMG_NUM)-1:0] src_addr_o,
    output logic [NUM_LAYERS-1:0] w_buf_en_o,
    output logic [$clog2(MAX_IN)-1:0] w_buf_addr_o,
    output logic mac_clr_o,
    output logic mac_valid_o,
    output logic mac_last_o,
    output logic [$clog2(MAX_OUT)-1:0] res_idx_o,
    input  logic [FP_BW-1:0] res_data_i,
    output logic tmp_wen_o,
    output logic tmp_sel_o,
    output logic [$clog2(MAX_OUT)-1:0] tmp_addr_o,
    output logic [FP_BW-1:0] tmp_data_o,
    output logic y_buf_en_o,
    output logic y_buf_wr_en_o,
    output logic [Y_ADDR_WIDTH-1:0] y_buf_addr_o,
    output logic [FP_BW-1:0] y_buf_data_o
);
    localparam int AW = $clog2(MAX_IN);
    localparam int SW = $clog2(MAX_IN*IMG_NUM);
    localparam int LW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
    localparam int IW = IMG_NUM > 1 ? $clog2(IMG_NUM) : 1;
    localparam int FL = RD_LATENCY + MAC_LATENCY;
    localparam int FW = $clog2(FL + 1);
    localparam int IN0 = int'(LAYER_IN[15:0]);
    localparam int OUT_LAST = int'(LAYER_OUT[16*(NUM_LAYERS-1) +: 16]);

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_chk
        if (LAYER_OUT[16*k +: 16] > MAX_OUT || LAYER_IN[16*k +: 16] > MAX_IN) begin : g_size
            $error("mlp_seq_ctrl: layer %0d exceeds MAX_IN/MAX_OUT", k);
        end
        if (k < NUM_LAYERS - 1) begin : g_link
            if (LAYER_IN[16*(k+1) +: 16] != LAYER_OUT[16*k +: 16]) begin : g_mis
                $error("mlp_seq_ctrl: layer %0d output length does not match next input", k);
            end
        end
    end

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, NEXT, DONE} state_t;

    state_t state;
    logic [LW-1:0] layer;
    logic [IW-1:0] img;
    logic [AW-1:0] row;
    logic [FW-1:0] fl;
    logic feed_last;
    logic [RD_LATENCY-1:0] vld_d, last_d;
    logic [15:0] in_len, out_len;
    logic [AW-1:0] nxt_row;
    logic last_layer;
    logic [1:0] src_sel;
    logic [SW-1:0] src_addr;
    logic [Y_ADDR_WIDTH-1:0] y_addr;

    assign in_len = LAYER_IN[16*layer +: 16];
    assign out_len = LAYER_OUT[16*layer +: 16];
    assign last_layer = layer == LW'(NUM_LAYERS - 1);
    assign nxt_row = state == CLEAR ? '0 : row + 1'b1;
    // Layer k>0 reads the temp buffer written by layer k-1.
    assign src_sel = layer == '0 ? 2'd0 : layer[0] ? 2'd1 : 2'd2;
    assign src_addr = SW'(nxt_row) + (layer == '0 ? SW'(img) * SW'(IN0) : '0);
    assign y_addr = Y_ADDR_WIDTH'((32'(img) * 32'(OUT_LAST) + 32'(res_idx_o)) * 32'(Y_ADDR_STEP));
    assign mac_valid_o = vld_d[RD_LATENCY-1];
    assign mac_last_o = last_d[RD_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            layer <= '0;
            img <= '0;
            row <= '0;
            fl <= '0;
            feed_last <= 1'b0;
            vld_d <= '0;
            last_d <= '0;
            done_intr_o <= 1'b0;
            done_led_o <= 1'b0;
            src_buf_en_o <= 1'b0;
            src_sel_o <= '0;
            src_addr_o <= '0;
            w_buf_en_o <= '0;
            w_buf_addr_o <= '0;
            mac_clr_o <= 1'b0;
            res_idx_o <= '0;
            tmp_wen_o <= 1'b0;
            tmp_sel_o <= 1'b0;
            tmp_addr_o <= '0;
            tmp_data_o <= '0;
            y_buf_en_o <= 1'b0;
            y_buf_wr_en_o <= 1'b0;
            y_buf_addr_o <= '0;
            y_buf_data_o <= '0;
        end else begin
            vld_d <= RD_LATENCY'({vld_d, src_buf_en_o});
            last_d <= RD_LATENCY'({last_d, feed_last});
            mac_clr_o <= 1'b0;
            src_buf_en_o <= 1'b0;
            w_buf_en_o <= '0;
            feed_last <= 1'b0;
            tmp_wen_o <= 1'b0;
            y_buf_en_o <= 1'b0;
            y_buf_wr_en_o <= 1'b0;
            done_intr_o <= 1'b0;
            // Result selected by res_idx_o this cycle lands in its buffer next cycle.
            if (state == DRAIN && last_layer) begin
                y_buf_en_o <= 1'b1;
                y_buf_wr_en_o <= 1'b1;
                y_buf_addr_o <= y_addr;
                y_buf_data_o <= res_data_i;
            end else if (state == DRAIN) begin
                tmp_wen_o <= 1'b1;
                tmp_sel_o <= layer[0];
                tmp_addr_o <= res_idx_o;
                tmp_data_o <= (RELU_EN != 0 && res_data_i[FP_BW-1]) ? '0 : res_data_i;
            end
            case (state)
                IDLE: if (start_i) begin
                    img <= '0;
                    layer <= '0;
                    done_led_o <= 1'b0;
                    mac_clr_o <= 1'b1;
                    state <= CLEAR;
                end
                CLEAR, FEED: if (feed_last) begin
                    fl <= '0;
                    state <= FLUSH;
                end else begin
                    row <= nxt_row;
                    src_buf_en_o <= 1'b1;
                    w_buf_en_o <= NUM_LAYERS'(1) << layer;
                    w_buf_addr_o <= nxt_row;
                    src_sel_o <= src_sel;
                    src_addr_o <= src_addr;
                    feed_last <= 16'(nxt_row) == in_len - 16'd1;
                    state <= FEED;
                end
                FLUSH: if (fl == FW'(FL - 1)) begin
                    res_idx_o <= '0;
                    state <= DRAIN;
                end else begin
                    fl <= fl + 1'b1;
                end
                DRAIN: if (16'(res_idx_o) == out_len - 16'd1) state <= NEXT;
                    else res_idx_o <= res_idx_o + 1'b1;
                NEXT: if (!last_layer) begin
                    layer <= layer + 1'b1;
                    mac_clr_o <= 1'b1;
                    state <= CLEAR;
                end else if (img != IW'(IMG_NUM - 1)) begin
                    img <= img + 1'b1;
                    layer <= '0;
                    mac_clr_o <= 1'b1;
                    state <= CLEAR;
                end else begin
                    state <= DONE;
                end
                DONE: begin
                    done_intr_o <= 1'b1;
                    done_led_o <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// tb_mlp_seq_ctrl: randomized-data bench comparing every cycle against a timeline model
// derived from per-layer phase lengths.
module tb_mlp_seq_ctrl;
    localparam int NL = 5;
    localparam int IMG = 2;
    localparam int RD = 3;
    localparam int MAC = 4;
    localparam int LIN [NL] = '{784, 64, 32, 32, 16};
    localparam int LOUT [NL] = '{64, 32, 32, 16, 10};

    typedef struct packed {
        logic clr, feed, flast, drain, wr;
        logic [2:0] k;
        logic [1:0] img;
        logic [9:0] row;
        logic [5:0] jd, jw;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n, start_i;
    logic done_intr_o, done_led_o, src_buf_en_o;
    logic [1:0] src_sel_o;
    logic [10:0] src_addr_o;
    logic [4:0] w_buf_en_o;
    logic [9:0] w_buf_addr_o;
    logic mac_clr_o, mac_valid_o, mac_last_o;
    logic [5:0] res_idx_o;
    logic [31:0] res_data_i;
    logic tmp_wen_o, tmp_sel_o;
    logic [5:0] tmp_addr_o;
    logic [31:0] tmp_data_o;
    logic y_buf_en_o, y_buf_wr_en_o;
    logic [31:0] y_buf_addr_o, y_buf_data_o;
    logic [31:0] pu [64];
    int checks = 0, errs = 0, dones = 0, per, tot;

    mlp_seq_ctrl #(.IMG_NUM(IMG), .RD_LATENCY(RD), .MAC_LATENCY(MAC)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .done_intr_o(done_intr_o), .done_led_o(done_led_o),
        .src_buf_en_o(src_buf_en_o), .src_sel_o(src_sel_o), .src_addr_o(src_addr_o),
        .w_buf_en_o(w_buf_en_o), .w_buf_addr_o(w_buf_addr_o),
        .mac_clr_o(mac_clr_o), .mac_valid_o(mac_valid_o), .mac_last_o(mac_last_o),
        .res_idx_o(res_idx_o), .res_data_i(res_data_i),
        .tmp_wen_o(tmp_wen_o), .tmp_sel_o(tmp_sel_o), .tmp_addr_o(tmp_addr_o), .tmp_data_o(tmp_data_o),
        .y_buf_en_o(y_buf_en_o), .y_buf_wr_en_o(y_buf_wr_en_o),
        .y_buf_addr_o(y_buf_addr_o), .y_buf_data_o(y_buf_data_o)
    );

    always #5 clk = ~clk;
    assign res_data_i = pu[res_idx_o];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t got=%h want=%h", tag, $time, act, exp);
        end
    endtask

    function automatic int lay_len(input int k);
        return 2 + LIN[k] + RD + MAC + LOUT[k];
    endfunction

    // Cycle t counts from the edge that accepted start (t=0 is the first CLEAR).
    function automatic ev_t ev_at(input int t);
        ev_t e = '0;
        int r, u, d0, k;
        if (t < 0 || t >= tot) return e;
        e.img = 2'(t / per);
        r = t % per;
        k = 0;
        while (r >= lay_len(k)) begin
            r -= lay_len(k);
            k++;
        end
        u = r;
        d0 = 1 + LIN[k] + RD + MAC;
        e.k = 3'(k);
        e.clr = u == 0;
        e.feed = u >= 1 && u <= LIN[k];
        e.flast = u == LIN[k];
        e.row = 10'(u - 1);
        e.drain = u >= d0 && u < d0 + LOUT[k];
        e.jd = 6'(u - d0);
        e.wr = u > d0 && u <= d0 + LOUT[k];
        e.jw = 6'(u - d0 - 1);
        return e;
    endfunction

    task automatic check_cyc(input int t);
        ev_t e, p;
        logic lk;
        e = ev_at(t);
        p = ev_at(t - RD);
        lk = e.k == 3'(NL - 1);
        dones += int'(done_intr_o);
        check("ctl", {mac_clr_o, src_buf_en_o, w_buf_en_o, mac_valid_o, mac_last_o, tmp_wen_o,
                      y_buf_en_o, y_buf_wr_en_o, done_intr_o, done_led_o},
                     {e.clr, e.feed, e.feed ? 5'(5'd1 << e.k) : 5'd0, p.feed, p.flast, e.wr && !lk,
                      e.wr && lk, e.wr && lk, t == tot + 1, t >= tot + 1});
        if (e.feed)
            check("src", {src_sel_o, src_addr_o, w_buf_addr_o},
                  {e.k == 0 ? 2'd0 : 2'(((int'(e.k) - 1) % 2) + 1),
                   11'(int'(e.row) + (e.k == 0 ? int'(e.img) * LIN[0] : 0)), e.row});
        if (e.drain)
            check("idx", res_idx_o, e.jd);
        if (e.wr && !lk)
            check("tmp", {tmp_sel_o, tmp_addr_o, tmp_data_o},
                  {e.k[0], e.jw, pu[e.jw][31] ? 32'd0 : pu[e.jw]});
        if (e.wr && lk)
            check("y", {y_buf_addr_o, y_buf_data_o},
                  {32'((int'(e.img) * LOUT[NL-1] + int'(e.jw)) * 4), pu[e.jw]});
    endtask

    task automatic run(input int t0, input int t1);
        for (int t = t0; t <= t1; t++) begin
            check_cyc(t);
            @(negedge clk);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_ctl"}, {done_intr_o, done_led_o, src_buf_en_o, src_sel_o, src_addr_o, w_buf_en_o,
                              w_buf_addr_o, mac_clr_o, mac_valid_o, mac_last_o, res_idx_o, tmp_wen_o,
                              tmp_sel_o, tmp_addr_o, y_buf_en_o, y_buf_wr_en_o}, 64'd0);
        check({tag, "_dat"}, {tmp_data_o, y_buf_data_o}, 64'd0);
        check({tag, "_yad"}, y_buf_addr_o, 64'd0);
    endtask

    task automatic fill_pu();
        for (int j = 0; j < 64; j++) pu[j] = $urandom;
        pu[0] = 32'hBF800000;
    endtask

    initial begin
        int t_rst;
        rst_n = 1'b0;
        start_i = 1'b0;
        per = 0;
        for (int k = 0; k < NL; k++) per += lay_len(k);
        tot = IMG * per;
        fill_pu();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        dones = 0;
        run(0, tot + 3);
        check("pulses", dones, 1);
        // start held through the whole run: restart only once back in IDLE
        fill_pu();
        start_i = 1'b1;
        @(negedge clk);
        run(0, tot + 1);
        start_i = 1'b0;
        t_rst = lay_len(0) + lay_len(1) + 11;
        run(0, t_rst - 1);
        check_cyc(t_rst);
        #1 rst_n = 1'b0;
        #1 chk_zero("arst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_cyc(-1);
            @(negedge clk);
        end
        fill_pu();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        dones = 0;
        run(0, tot + 2);
        check("pulses2", dones, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mlp_seq_ctrl.md
# mlp_seq_ctrl

Parametrised layer sequencer for the MLP accelerator. It replaces the fixed five-layer global controller with one engine that walks any number of fully-connected layers over one or more images. For each layer it:
- streams input-vector and weight-row reads,
- drives the MAC array handshake,
- drains results into ping-pong temp buffers (with optional ReLU) or into the output buffer.

It sits between the system start/done interface and the x, w, temp and y buffers plus the PU.

## Interface
- NUM_LAYERS, 5, layer count (>=1)
- IMG_NUM, 1, images processed per start
- MAX_IN, 784, largest layer input length
- MAX_OUT, 64, largest layer output length (PU column count)
- LAYER_IN, {16'd16,16'd32,16'd32,16'd64,16'd784}, packed input lengths, layer k at bits [16k+15:16k]
- LAYER_OUT, {16'd10,16'd16,16'd32,16'd32,16'd64}, packed output lengths, same packing
- FP_BW, 32, data width
- RD_LATENCY, 1, buffer read latency in cycles (>=1)
- MAC_LATENCY, 4, cycles from last mac_valid_o until PU results are stable
- RELU_EN, 1, apply ReLU on intermediate layers
- Y_ADDR_STEP, 4, y address increment per word
- Y_ADDR_WIDTH, 32, y address width

Ports (AW = $clog2(MAX_IN), OW = $clog2(MAX_OUT)):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start request, sampled only in IDLE
- done_intr_o  out  1  one-cycle completion pulse
- done_led_o  out  1  set at completion, cleared on next accepted start
- src_buf_en_o  out  1  source read enable
- src_sel_o  out  2  read source: 0 = x buffer, 1 = ping, 2 = pong
- src_addr_o  out  $clog2(MAX_IN*IMG_NUM)  source read address
- w_buf_en_o  out  NUM_LAYERS  one-hot weight buffer enable
- w_buf_addr_o  out  AW  weight row address
- mac_clr_o  out  1  clear PU accumulators
- mac_valid_o  out  1  source/weight data valid at PU this cycle
- mac_last_o  out  1  marks last valid row of the layer
- res_idx_o  out  OW  PU result column select
- res_data_i  in  FP_BW  selected PU result, combinational from res_idx_o
- tmp_wen_o  out  1  temp buffer write
- tmp_sel_o  out  1  write target: 0 = ping, 1 = pong
- tmp_addr_o  out  OW  temp write address
- tmp_data_o  out  FP_BW  temp write data
- y_buf_en_o, y_buf_wr_en_o  out  1 each  output buffer enable and write
- y_buf_addr_o  out  Y_ADDR_WIDTH  output byte address
- y_buf_data_o  out  FP_BW  output data

## Operation
- FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN, NEXT, DONE. All outputs are driven from flops.
- IDLE: on start_i, set img=0 and layer=0, clear done_led_o, go to CLEAR. start_i is ignored in every other state.
- CLEAR: mac_clr_o=1 for one cycle, row=0, then FEED.
- FEED: one row per cycle.
  - src_buf_en_o=1 and w_buf_en_o[layer]=1.
  - w_buf_addr_o = row.
  - src_addr_o = row + img*LAYER_IN[0] on layer 0, else row.
  - After row LAYER_IN[layer]-1, go to FLUSH.
- mac_valid_o/mac_last_o: the FEED enable and last-row flag, delayed by exactly RD_LATENCY cycles.
- FLUSH: wait RD_LATENCY+MAC_LATENCY cycles, then DRAIN with j=0.
- DRAIN: res_idx_o=j for j = 0..LAYER_OUT[layer]-1, one per cycle, then NEXT.
  - Each sample of res_data_i is written one cycle later.
  - Intermediate layer: tmp_wen_o=1, tmp_sel_o = layer%2, tmp_addr_o = j. Data is 0 if RELU_EN and sign bit set, else res_data_i.
  - Last layer: y_buf_en_o = y_buf_wr_en_o = 1, y_buf_addr_o = (img*LAYER_OUT[last]+j)*Y_ADDR_STEP, data unmodified.
- Source select: layer 0 reads x (sel 0). Layer k>0 reads sel 1+((k-1)%2), i.e. the buffer written by layer k-1.
- NEXT (the last drain write lands in this cycle):
  - if layer<NUM_LAYERS-1: layer++, go to CLEAR;
  - else if img<IMG_NUM-1: img++, layer=0, go to CLEAR;
  - else go to DONE.
- DONE: done_intr_o=1 for one cycle, done_led_o=1, return to IDLE.
- Elaboration error if any LAYER_OUT[k] > MAX_OUT, LAYER_IN[k] > MAX_IN, or LAYER_IN[k+1] != LAYER_OUT[k].

## Timing
- Reset: state IDLE, all counters and every output 0, including done_led_o and the delay lines.
- Layer cycle count: 1 + LAYER_IN + RD_LATENCY + MAC_LATENCY + LAYER_OUT + 1.
- Defaults: 1117 cycles per image. start_i sampled at edge E0 gives done_intr_o high in the cycle after edge E0 + 1 + 1117*IMG_NUM.
- mac_clr_o precedes the first mac_valid_o of its layer by RD_LATENCY+1 cycles.
- Reset mid-operation: immediate return to IDLE. No further writes, no done pulse.
- Counters are sized for MAX_IN/MAX_OUT and never wrap within a legal configuration.

## Test plan
- Default params, start pulse → exactly 1 done_intr_o pulse at E0+1118. y writes at addresses 0,4,…,36 with res_data_i passed through. w_buf_en_o walks 00001→10000.
- Layer 0 drain, res_data_i=32'hBF800000 → tmp_data_o=0 at ping addresses 0..63. Same value on the last layer → y_buf_data_o=32'hBF800000. With RELU_EN=0 → unchanged in temp.
- IMG_NUM=2 → second pass src_addr_o runs 784..1567, y addresses 40..76. Exactly one done pulse.
- RD_LATENCY=3 → mac_valid_o high exactly 784 cycles, starting 3 cycles after the first FEED. mac_last_o is coincident with the final valid.
- start_i held high during run and after DONE → no restart until IDLE. A new start clears done_led_o.
- rst_n low during layer-2 FEED → all outputs 0 asynchronously. A fresh start then completes normally in 1118 cycles.
